hazard_ctrl: RTL and testbench

- Central pipeline-control unit for the 5-stage RV32I + P-extension core.
- Drives the `en`/`flush` pairs of the IF/ID, ID/EX and EX/MEM pipeline registers, and the PC enable.
- Resolves three hazards: load-use stalls, taken-branch/jump redirects, and multi-cycle P-extension EX operations, using a start/done handshake with a timeout watchdog.
- Also keeps saturating stall/flush performance counters.

---
 rtl/hazard_ctrl.sv | 151 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard control for the 5-stage RV32I + P-ext core
//
// Purpose: drives the PC enable and the en/flush pairs of the IF/ID, ID/EX and
// EX/MEM pipeline registers. Resolves load-use stalls, taken branch/jump
// redirects and multi-cycle P-extension EX ops (start/done handshake guarded by
// a timeout watchdog). Keeps saturating stall/flush performance counters.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   id_rs1/id_rs2, id_uses_rs*    source registers of the ID instruction
//   ex_rd, ex_reg_write, ex_is_load  destination info of the EX instruction
//   ex_mc_req                     EX instruction is a multi-cycle op
//   mc_done                       multi-cycle result valid (1-cycle pulse)
//   ex_redirect                   branch/jump taken in EX
//   pc_en, *_en, *_flush          pipeline register controls (flush wins over en)
//   mc_start                      1-cycle launch pulse to the multi-cycle unit
//   mc_err                        sticky multi-cycle timeout flag
//   stall_cnt, flush_cnt          saturating performance counters

module hazard_ctrl #(
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_is_load,
  input  logic             ex_mc_req,
  input  logic             mc_done,
  input  logic             ex_redirect,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mc_start,
  output logic             mc_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [0:0] RUN     = 1'b0;
  localparam logic [0:0] MC_WAIT = 1'b1;

  localparam int WAIT_W = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MC_TIMEOUT - 1);

  logic [0:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              mc_err_q, mc_err_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic load_use;

  // x0 is hard-wired zero, so a load targeting it can never create a hazard.
  assign load_use = ex_is_load & ex_reg_write & (ex_rd != 5'd0) &
                    ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                     (id_uses_rs2 & (id_rs2 == ex_rd)));

  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mc_start     = 1'b0;
    state_d      = state_q;
    wait_d       = wait_q;
    mc_err_d     = mc_err_q;

    if (state_q == RUN) begin
      if (ex_mc_req) begin
        // Freeze everything upstream of EX; the op itself stays in EX while
        // EX/MEM receives bubbles until the result arrives.
        mc_start     = 1'b1;
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_flush = 1'b1;
        state_d      = MC_WAIT;
        wait_d       = '0;
      end else if (ex_redirect) begin
        // Wrong-path IF and ID instructions are squashed; overrides load-use.
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        // Hold IF and ID one cycle; the load proceeds, a bubble enters EX.
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end
    end else begin
      if (mc_done) begin
        // Release; EX/MEM captures the multi-cycle result this cycle.
        state_d = RUN;
      end else if (wait_q == WAIT_LAST) begin
        // Watchdog expired: drop the op, unfreeze the pipe, flag the error.
        ex_mem_flush = 1'b1;
        mc_err_d     = 1'b1;
        state_d      = RUN;
      end else begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_flush = 1'b1;
        wait_d       = wait_q + 1'b1;
      end
    end

    stall_cnt_d = stall_cnt_q;
    if (!pc_en && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end

    flush_cnt_d = flush_cnt_q;
    if (if_id_flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      wait_q      <= '0;
      mc_err_q    <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      mc_err_q    <= mc_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign mc_err    = mc_err_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl

module tb_hazard_ctrl;

  logic       clk;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs1, id_uses_rs2;
  logic       ex_reg_write, ex_is_load, ex_mc_req, mc_done, ex_redirect;
  logic       pc_en, if_id_en, id_ex_en, ex_mem_en;
  logic       if_id_flush, id_ex_flush, ex_mem_flush;
  logic       mc_start, mc_err;
  logic [3:0] stall_cnt, flush_cnt;

  int total = 0;
  int bad   = 0;

  hazard_ctrl #(.MC_TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
    .ex_mc_req(ex_mc_req), .mc_done(mc_done), .ex_redirect(ex_redirect),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .mc_start(mc_start), .mc_err(mc_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_rd = 5'd0; ex_reg_write = 1'b0; ex_is_load = 1'b0;
    ex_mc_req = 1'b0; mc_done = 1'b0; ex_redirect = 1'b0;
  endtask

  task automatic set_load_use();
    ex_is_load = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd5;
    id_rs1 = 5'd3; id_uses_rs1 = 1'b1;
    id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    set_idle();
    rst_n = 1'b0;
    #3;
    total++;
    if ({pc_en, if_id_en, id_ex_en, ex_mem_en} !== 4'b1111) begin
      bad++; $display("FAIL reset_en: got %b want 1111", {pc_en, if_id_en, id_ex_en, ex_mem_en});
    end
    total++;
    if ({if_id_flush, id_ex_flush, ex_mem_flush, mc_start, mc_err} !== 5'b0) begin
      bad++; $display("FAIL reset_flush: got %b want 00000",
                      {if_id_flush, id_ex_flush, ex_mem_flush, mc_start, mc_err});
    end
    total++;
    if ({stall_cnt, flush_cnt} !== 8'h00) begin
      bad++; $display("FAIL reset_cnt: got %h want 00", {stall_cnt, flush_cnt});
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    set_load_use();
    #1;
    total++;
    if ({pc_en, if_id_en, id_ex_flush, ex_mem_en, if_id_flush, ex_mem_flush} !== 6'b001100) begin
      bad++; $display("FAIL load_use_stall: got %b want 001100",
                      {pc_en, if_id_en, id_ex_flush, ex_mem_en, if_id_flush, ex_mem_flush});
    end
    tick();
    set_idle();
    #1;
    total++;
    if ({pc_en, if_id_en, id_ex_en, ex_mem_en, id_ex_flush} !== 5'b11110) begin
      bad++; $display("FAIL load_use_release: got %b want 11110",
                      {pc_en, if_id_en, id_ex_en, ex_mem_en, id_ex_flush});
    end
    total++;
    if (stall_cnt !== 4'd1) begin
      bad++; $display("FAIL load_use_cnt: got %0d want 1", stall_cnt);
    end
  endtask

  task automatic test_load_x0();
    do_reset();
    ex_is_load = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd0;
    id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
    #1;
    total++;
    if ({pc_en, if_id_en, id_ex_flush} !== 3'b110) begin
      bad++; $display("FAIL load_x0: got %b want 110", {pc_en, if_id_en, id_ex_flush});
    end
    tick();
    set_idle();
    total++;
    if (stall_cnt !== 4'd0) begin
      bad++; $display("FAIL load_x0_cnt: got %0d want 0", stall_cnt);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    set_load_use();
    ex_redirect = 1'b1;
    #1;
    total++;
    if ({pc_en, if_id_flush, id_ex_flush, ex_mem_en, ex_mem_flush} !== 5'b11110) begin
      bad++; $display("FAIL redirect: got %b want 11110",
                      {pc_en, if_id_flush, id_ex_flush, ex_mem_en, ex_mem_flush});
    end
    tick();
    set_idle();
    #1;
    total++;
    if ({flush_cnt, stall_cnt} !== 8'h10) begin
      bad++; $display("FAIL redirect_cnt: got flush=%0d stall=%0d want 1/0", flush_cnt, stall_cnt);
    end
    total++;
    if ({if_id_flush, id_ex_flush, pc_en} !== 3'b001) begin
      bad++; $display("FAIL redirect_after: got %b want 001", {if_id_flush, id_ex_flush, pc_en});
    end
  endtask

  task automatic test_multicycle();
    int frozen;
    int starts;
    do_reset();
    ex_mc_req = 1'b1;
    #1;
    total++;
    if ({mc_start, pc_en, if_id_en, id_ex_en, ex_mem_flush} !== 5'b10001) begin
      bad++; $display("FAIL mc_launch: got %b want 10001",
                      {mc_start, pc_en, if_id_en, id_ex_en, ex_mem_flush});
    end
    frozen = 1;
    starts = 1;
    tick();
    // Wait-state hazards must be ignored while frozen.
    ex_mc_req = 1'b0;
    set_load_use();
    ex_redirect = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (pc_en === 1'b0 && ex_mem_flush === 1'b1 && id_ex_en === 1'b0 && if_id_flush === 1'b0)
        frozen++;
      if (mc_start !== 1'b0) starts++;
      tick();
    end
    total++;
    if (frozen !== 4) begin
      bad++; $display("FAIL mc_frozen: got %0d want 4", frozen);
    end
    total++;
    if (starts !== 1) begin
      bad++; $display("FAIL mc_start_pulses: got %0d want 1", starts);
    end
    set_idle();
    mc_done = 1'b1;
    #1;
    total++;
    if ({pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, ex_mem_flush} !== 7'b1111000) begin
      bad++; $display("FAIL mc_done_cycle: got %b want 1111000",
                      {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, ex_mem_flush});
    end
    tick();
    // Stray mc_done in RUN must be ignored.
    #1;
    total++;
    if ({pc_en, ex_mem_flush, mc_start, mc_err} !== 4'b1000) begin
      bad++; $display("FAIL mc_back_in_run: got %b want 1000", {pc_en, ex_mem_flush, mc_start, mc_err});
    end
    tick();
    set_idle();
    total++;
    if (stall_cnt !== 4'd4) begin
      bad++; $display("FAIL mc_stall_cnt: got %0d want 4", stall_cnt);
    end
  endtask

  task automatic test_timeout();
    int frozen;
    do_reset();
    ex_mc_req = 1'b1;
    #1;
    frozen = 0;
    for (int i = 0; i < 12; i++) begin
      if (pc_en === 1'b1) break;
      frozen++;
      tick();
      ex_mc_req = 1'b0;
      #1;
    end
    total++;
    if (frozen !== 4) begin
      bad++; $display("FAIL timeout_frozen: got %0d want 4", frozen);
    end
    total++;
    if ({pc_en, if_id_en, id_ex_en, ex_mem_en, ex_mem_flush} !== 5'b11111) begin
      bad++; $display("FAIL timeout_release: got %b want 11111",
                      {pc_en, if_id_en, id_ex_en, ex_mem_en, ex_mem_flush});
    end
    tick();
    repeat (3) tick();
    #1;
    total++;
    if ({mc_err, pc_en, ex_mem_flush} !== 3'b110) begin
      bad++; $display("FAIL timeout_err: got %b want 110", {mc_err, pc_en, ex_mem_flush});
    end
  endtask

  task automatic test_reset_mid_wait();
    ex_mc_req = 1'b1;
    tick();
    ex_mc_req = 1'b0;
    tick();
    #1;
    total++;
    if ({pc_en, mc_err, stall_cnt} !== {1'b0, 1'b1, 4'd6}) begin
      bad++; $display("FAIL pre_reset: got pc_en=%b mc_err=%b stall=%0d want 0/1/6",
                      pc_en, mc_err, stall_cnt);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({pc_en, if_id_en, id_ex_en, ex_mem_flush, mc_start, mc_err} !== 6'b111000) begin
      bad++; $display("FAIL reset_mid_wait: got %b want 111000",
                      {pc_en, if_id_en, id_ex_en, ex_mem_flush, mc_start, mc_err});
    end
    total++;
    if ({stall_cnt, flush_cnt} !== 8'h00) begin
      bad++; $display("FAIL reset_mid_wait_cnt: got %h want 00", {stall_cnt, flush_cnt});
    end
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    total++;
    if ({pc_en, ex_mem_flush, stall_cnt} !== {1'b1, 1'b0, 4'd0}) begin
      bad++; $display("FAIL after_reset_run: got pc_en=%b flush=%b stall=%0d want 1/0/0",
                      pc_en, ex_mem_flush, stall_cnt);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      set_load_use();
      tick();
      set_idle();
      tick();
    end
    total++;
    if (stall_cnt !== 4'd15) begin
      bad++; $display("FAIL stall_saturate: got %0d want 15", stall_cnt);
    end
    for (int i = 0; i < 20; i++) begin
      ex_redirect = 1'b1;
      tick();
    end
    set_idle();
    total++;
    if ({flush_cnt, stall_cnt} !== 8'hFF) begin
      bad++; $display("FAIL flush_saturate: got flush=%0d stall=%0d want 15/15", flush_cnt, stall_cnt);
    end
  endtask

  initial begin
    set_idle();
    rst_n = 1'b1;
    #2;
    test_reset();
    test_load_use();
    test_load_x0();
    test_redirect();
    test_multicycle();
    test_timeout();
    test_reset_mid_wait();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
